// File: rtl/sobol_pkg.sv
// Shared types for the Sobol index sequencer.
// States, sample bundle and dimension-width helper.
package sobol_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam int SKIP_DEF  = 1;
  localparam int DIM_MAX_W = 16;

  typedef struct packed {
    logic [31:0]          data;
    logic [31:0]          path;
    logic [DIM_MAX_W-1:0] dim;
    logic                 last;
  } sample_t;

  // M=1 still needs a one-bit dimension field
  function automatic int dim_w(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sobol_out_slice.sv
// Single-entry valid/ready output register.
// A load wins over a same-cycle handshake clear.
module sobol_out_slice
  import sobol_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load_i,
  input  logic    ready_i,
  input  sample_t d_i,
  output logic    valid_o,
  output sample_t q_o
);

  logic    valid_q;
  sample_t data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/sobol_index_seq.sv
// Raster-order (dim fastest) index sequencer for the Sobol generator.
// Captures generator output into a tagged valid/ready sample stream.
module sobol_index_seq
  import sobol_pkg::*;
#(
  parameter int M     = 50,
  parameter int SKIP  = SKIP_DEF,
  parameter int DIM_W = dim_w(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      num_paths,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sob_n,
  output logic [DIM_W-1:0] sob_dim,
  input  logic [31:0]      sob_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [31:0]      out_path,
  output logic [DIM_W-1:0] out_dim,
  output logic             out_last
);

  localparam logic [DIM_W-1:0] DIM_LAST = DIM_W'(M - 1);

  state_e           state_q;
  logic [31:0]      path_q;
  logic [DIM_W-1:0] dim_q;
  logic [31:0]      np_q;
  logic             busy_q;
  logic             done_q;

  logic    issue;
  logic    is_last;
  sample_t smp_d;
  sample_t smp_q;
  logic    unused_dim_hi;

  assign issue   = (state_q == RUN) && (!out_valid || out_ready);
  assign is_last = (path_q == np_q - 32'd1) && (dim_q == DIM_LAST);

  always_comb begin
    smp_d      = '0;
    smp_d.data = sob_in;
    smp_d.path = path_q;
    smp_d.dim  = DIM_MAX_W'(dim_q);
    smp_d.last = is_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      path_q  <= '0;
      dim_q   <= '0;
      np_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && num_paths != 32'd0) begin
            np_q    <= num_paths;
            path_q  <= '0;
            dim_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else if (start) begin
            done_q <= 1'b1;
          end
        end
        RUN: begin
          // hold counters on the last issue so sob_n never passes the range
          if (issue && is_last) begin
            state_q <= DRAIN;
          end else if (issue && dim_q == DIM_LAST) begin
            dim_q  <= '0;
            path_q <= path_q + 32'd1;
          end else if (issue) begin
            dim_q <= dim_q + DIM_W'(1);
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sobol_out_slice u_slice (
    .clk    (clk),
    .rst    (rst),
    .load_i (issue),
    .ready_i(out_ready),
    .d_i    (smp_d),
    .valid_o(out_valid),
    .q_o    (smp_q)
  );

  assign unused_dim_hi = ^smp_q.dim;

  assign sob_n    = path_q + 32'(SKIP);
  assign sob_dim  = dim_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = smp_q.data;
  assign out_path = smp_q.path;
  assign out_dim  = smp_q.dim[DIM_W-1:0];
  assign out_last = smp_q.last;

endmodule

// File: tb/tb_sobol_index_seq.sv
// Scoreboard bench for sobol_index_seq with a stand-in generator.
// Dim 0 of the stand-in is the true Sobol (bit-reversed N) sequence.
module tb_sobol_index_seq;

  localparam int M = 4;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [31:0] num_paths;
  logic        busy, done, out_valid, out_last;
  logic [31:0] sob_n, sob_in, out_data, out_path;
  logic [1:0]  sob_dim, out_dim;

  logic        start0, ready0;
  logic [31:0] np0;
  logic        busy0, done0, valid0, last0;
  logic [31:0] sob_n0, sob_in0, data0, path0;
  logic [1:0]  sob_dim0, dim0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic [31:0] path;
    logic [1:0]  dim;
    logic        last;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] bitrev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = x[i];
    return r;
  endfunction

  function automatic logic [31:0] gen(input logic [31:0] n,
                                      input logic [1:0] d);
    logic [31:0] r;
    r = bitrev(n);
    return (d == 2'd0) ? r : (r ^ (r >> d));
  endfunction

  assign sob_in  = gen(sob_n, sob_dim);
  assign sob_in0 = gen(sob_n0, sob_dim0);

  sobol_index_seq #(.M(M), .SKIP(1)) dut (
    .clk(clk), .rst(rst), .start(start), .num_paths(num_paths),
    .busy(busy), .done(done), .sob_n(sob_n), .sob_dim(sob_dim),
    .sob_in(sob_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_path(out_path), .out_dim(out_dim),
    .out_last(out_last)
  );

  sobol_index_seq #(.M(M), .SKIP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .num_paths(np0),
    .busy(busy0), .done(done0), .sob_n(sob_n0), .sob_dim(sob_dim0),
    .sob_in(sob_in0), .out_valid(valid0), .out_ready(ready0),
    .out_data(data0), .out_path(path0), .out_dim(dim0),
    .out_last(last0)
  );

  task automatic push_exp(input int np);
    exp_t e;
    sb.delete();
    for (int p = 0; p < np; p++)
      for (int d = 0; d < M; d++) begin
        e.data = gen(32'(p + 1), 2'(d));
        e.path = 32'(p);
        e.dim  = 2'(d);
        e.last = (p == np - 1) && (d == M - 1);
        sb.push_back(e);
      end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s extra: got path=%0d dim=%0d want none",
               name, out_path, out_dim);
    end else begin
      e = sb.pop_front();
      if (out_data !== e.data || out_path !== e.path ||
          out_dim !== e.dim || out_last !== e.last) begin
        errors++;
        $display("FAIL %s sample: got %h/%0d/%0d/%b want %h/%0d/%0d/%b",
                 name, out_data, out_path, out_dim, out_last,
                 e.data, e.path, e.dim, e.last);
      end
    end
  endtask

  task automatic run_seq(input string name, input int np,
                         input bit bp, input bit restart,
                         input bit chk_dim0);
    int c, ndone, nsamp, done_c;
    logic pv, pr;
    logic [31:0] pd, pp;
    logic [1:0] pdim;
    logic pl;
    logic [31:0] tab [3];
    tab[0] = 32'h8000_0000;
    tab[1] = 32'h4000_0000;
    tab[2] = 32'hC000_0000;
    push_exp(np);
    @(negedge clk);
    start = 1'b1; num_paths = 32'(np); out_ready = 1'b1;
    c = 0; ndone = 0; nsamp = 0; done_c = -1; pv = 1'b0; pr = 1'b1;
    pd = '0; pp = '0; pdim = '0; pl = 1'b0;
    while (c < np * M * 3 + 40) begin
      @(negedge clk);
      c++;
      start = restart && (c == 5);
      if (restart && c == 5) num_paths = 32'd7;
      out_ready = !bp || (c % 4 == 0) || (c % 4 == 3) ||
                  ($urandom_range(0, 1) == 1);
      #1;
      if (pv && !pr) begin
        checks++;
        if (!out_valid || out_data !== pd || out_path !== pp ||
            out_dim !== pdim || out_last !== pl) begin
          errors++;
          $display("FAIL %s stall: got %b/%h/%0d/%0d want 1/%h/%0d/%0d",
                   name, out_valid, out_data, out_path, out_dim,
                   pd, pp, pdim);
        end
      end
      checks++;
      if (busy !== (ndone == 0 && !done)) begin
        errors++;
        $display("FAIL %s busy c=%0d: got %b want %b",
                 name, c, busy, (ndone == 0 && !done));
      end
      if (done) begin
        ndone++;
        if (ndone == 1) done_c = c;
      end
      if (out_valid && out_ready) begin
        if (chk_dim0 && out_dim == 2'd0 && out_path < 3) begin
          checks++;
          if (out_data !== tab[out_path]) begin
            errors++;
            $display("FAIL %s dim0 p%0d: got %h want %h",
                     name, out_path, out_data, tab[out_path]);
          end
        end
        pop_check(name);
        nsamp++;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      pp = out_path; pdim = out_dim; pl = out_last;
      if (ndone > 0 && c >= done_c + 3) break;
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d want 1", name, ndone);
    end
    checks++;
    if (nsamp !== np * M || sb.size() !== 0) begin
      errors++;
      $display("FAIL %s samples: got %0d left %0d want %0d left 0",
               name, nsamp, sb.size(), np * M);
    end
    if (!bp) begin
      checks++;
      if (done_c !== np * M + 2) begin
        errors++;
        $display("FAIL %s done_time: got %0d want %0d",
                 name, done_c, np * M + 2);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_paths = '0; out_ready = 1'b0;
    start0 = 1'b0; np0 = '0; ready0 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || out_valid !== 0 ||
        out_data !== 0 || out_path !== 0 || out_dim !== 0 ||
        out_last !== 0 || sob_n !== 32'd1 || sob_dim !== 0) begin
      errors++;
      $display("FAIL reset: got b%b d%b v%b %h %0d %0d %b n%0d want 0s n1",
               busy, done, out_valid, out_data, out_path, out_dim,
               out_last, sob_n);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_paths();
    @(negedge clk);
    start = 1'b1; num_paths = '0; out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (done !== (c == 1) || busy !== 0 || out_valid !== 0) begin
        errors++;
        $display("FAIL zero c=%0d: got d%b b%b v%b want d%b b0 v0",
                 c, done, busy, out_valid, (c == 1));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int hs;
    int c;
    push_exp(3);
    @(negedge clk);
    start = 1'b1; num_paths = 32'd3; out_ready = 1'b1;
    hs = 0; c = 0;
    while (hs < 5 && c < 30) begin
      @(negedge clk);
      start = 1'b0;
      c++;
      #1;
      if (out_valid && out_ready) begin
        pop_check("abort");
        hs++;
      end
    end
    checks++;
    if (hs !== 5) begin
      errors++;
      $display("FAIL abort_pre: got %0d want 5", hs);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 0 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL abort: got v%b b%b d%b want 0 0 0",
               out_valid, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done !== 0 || busy !== 0 || out_valid !== 0) begin
        errors++;
        $display("FAIL abort_idle: got d%b b%b v%b want 0 0 0",
                 done, busy, out_valid);
      end
    end
  endtask

  task automatic test_skip0();
    int k;
    int c;
    @(negedge clk);
    start0 = 1'b1; np0 = 32'd1;
    k = 0; c = 0;
    while (c < 20) begin
      @(negedge clk);
      start0 = 1'b0;
      c++;
      #1;
      if (c == 1) begin
        checks++;
        if (sob_n0 !== 32'd0 || sob_dim0 !== 2'd0) begin
          errors++;
          $display("FAIL skip0_n: got %0d/%0d want 0/0", sob_n0, sob_dim0);
        end
      end
      if (valid0) begin
        checks++;
        if (data0 !== 0 || path0 !== 0 || dim0 !== 2'(k) ||
            last0 !== (k == M - 1)) begin
          errors++;
          $display("FAIL skip0 k=%0d: got %h/%0d/%0d/%b want 0/0/%0d/%b",
                   k, data0, path0, dim0, last0, k, (k == M - 1));
        end
        k++;
      end
      if (done0) break;
    end
    checks++;
    if (k !== M || done0 !== 1) begin
      errors++;
      $display("FAIL skip0_count: got %0d done %b want %0d done 1",
               k, done0, M);
    end
  endtask

  initial begin
    test_reset();
    run_seq("main", 3, 1'b0, 1'b0, 1'b1);
    test_zero_paths();
    run_seq("backpressure", 5, 1'b1, 1'b0, 1'b1);
    test_skip0();
    test_reset_mid_run();
    run_seq("after_abort", 3, 1'b0, 1'b0, 1'b1);
    run_seq("restart", 3, 1'b0, 1'b1, 1'b0);
    run_seq("back_to_back", 2, 1'b0, 1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sobol_index_seq.md
Name: sobol_index_seq

Overview:
- Upstream sequencer for the combinational Sobol generator.
- Walks path index N and dimension dim in raster order: dim fastest, 0..M-1, then the next path.
- Drives the generator's N/dim inputs and captures the returned sample into an output register.
- Emits a tagged sample stream with valid/ready backpressure, consumed by the inverse-CDF / path-generation stage.

Parameters:
- M, 50, number of Sobol dimensions (time steps); must match the generator.
- SKIP, 1, offset added to path index to form N; 1 skips the all-zero point N=0; legal values 0 or 1.
- DIM_W, $clog2(M), width of dimension fields.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset; single clock domain, synchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- num_paths  in  32  paths to generate; latched on accepted start.
- busy  out  1  high from cycle after accepted start until done pulse.
- done  out  1  one-cycle pulse after last sample handshaked.
- sob_n  out  32  path index to generator, equal to path_cnt + SKIP.
- sob_dim  out  DIM_W  dimension to generator, equal to dim_cnt.
- sob_in  in  32  generator result for current sob_n/sob_dim (combinational return).
- out_valid  out  1  output register holds a sample.
- out_ready  in  1  downstream accepts.
- out_data  out  32  Sobol sample (unsigned 0.32 fraction).
- out_path  out  32  0-based path index of sample.
- out_dim  out  DIM_W  dimension of sample.
- out_last  out  1  sample is final of run (last path, dim M-1).

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_path=0, out_dim=0, out_last=0, path_cnt=0, dim_cnt=0, state=IDLE.
- Reset mid-run aborts immediately; no done pulse; next cycle idle.
- States: IDLE, RUN, DRAIN.
- IDLE + start with num_paths>0: latch num_paths, clear counters, go RUN.
- IDLE + start with num_paths==0: no RUN; done pulses next cycle, busy stays 0, no samples.
- start while not IDLE is ignored.
- RUN issue condition: issue = !out_valid || out_ready.
- On issue: out_data<=sob_in, out_path<=path_cnt, out_dim<=dim_cnt, out_valid<=1, out_last<=(path_cnt==np-1 && dim_cnt==M-1).
- On issue, advance: dim_cnt+1; at M-1, wrap to 0 and increment path_cnt.
- Issuing the last sample moves RUN -> DRAIN.
- When no issue: counters and output register hold; sob_n/sob_dim stable.
- DRAIN: on out_valid && out_ready, clear out_valid, pulse done, go IDLE.
- out_valid clears on handshake in any state unless a new issue occurs the same cycle.
- Output fields are stable while out_valid && !out_ready.
- Latency: start at cycle t -> RUN at t+1 -> first out_valid at t+2.
- Throughput: 1 sample/cycle with out_ready held high; run completes in num_paths*M + 2 cycles to done.
- Width: sob_n is a 32-bit add, no wrap; caller guarantees num_paths+SKIP <= 2^32 (max num_paths 0xFFFFFFFF with SKIP=1 gives last N 0xFFFFFFFF).
- Output is M-1 dim wide only via DIM_W; M=1 legal (DIM_W forced >=1).

Decomposition:
- Package sobol_pkg: state enum (IDLE/RUN/DRAIN), SKIP default, DIM_W helper function, sample struct {data, path, dim, last}.
- Sub-module sobol_out_slice: single-entry valid/ready register holding the sample struct; the sequencer FSM and counters stay in the top.
- Generator instantiated by the parent, not inside this block.

Test Plan:
- M=4, SKIP=1, num_paths=3, out_ready=1, generator attached: dim0 outputs 0x80000000, 0x40000000, 0xC0000000 for paths 0..2; 12 samples; out_last only on path 2 dim 3; done at start+14.
- num_paths=0: start -> done one cycle later, busy never 1, out_valid never 1.
- Backpressure: out_ready toggled 1,0,0,1 pseudo-random -> outputs held stable while stalled; no sample dropped or duplicated; order matches raster.
- SKIP=0, num_paths=1: first sample sob_n=0, out_data=0 for all dims.
- rst asserted mid-run after 5 samples -> next cycle out_valid=0, busy=0, no done; new start then runs a full, correct sequence from path 0.
- start pulsed again during RUN -> ignored; sample count still num_paths*M; single done pulse.
